// File: rtl/hs_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : hs_rr_arbiter
// Description : N-channel ready/ack request controller granting one request
//               at a time to a shared consumer, round-robin, with timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module hs_rr_arbiter #(
    parameter  int NUM_CH = 4,
    parameter  int TMO_W  = 8,
    localparam int ID_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ch_req,
    output logic [NUM_CH-1:0] ch_ready,
    output logic [NUM_CH-1:0] ch_ack,
    output logic [NUM_CH-1:0] ch_err,
    output logic              dst_valid,
    output logic [ID_W-1:0]   dst_id,
    input  logic              dst_done,
    input  logic [TMO_W-1:0]  tmo_limit,
    output logic              busy
);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    state_t             r_state,   w_state_nxt;
    logic [NUM_CH-1:0]  r_pending, w_pending_nxt;
    logic [NUM_CH-1:0]  r_ack,     w_ack_nxt;
    logic [NUM_CH-1:0]  r_err,     w_err_nxt;
    logic               r_valid,   w_valid_nxt;
    logic [ID_W-1:0]    r_id,      w_id_nxt;
    logic [ID_W-1:0]    r_last,    w_last_nxt;
    logic [TMO_W-1:0]   r_cnt,     w_cnt_nxt;

    logic [NUM_CH-1:0]  w_id_oh;
    logic               w_pick_found;
    logic [ID_W-1:0]    w_pick_id;
    logic [ID_W:0]      w_cand;

    assign w_id_oh = NUM_CH'(1) << r_id;

    // Search upward from the channel after last_grant, wrapping once round.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_id    = '0;
        w_cand       = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            w_cand = {1'b0, r_last} + (ID_W+1)'(k);
            if (w_cand >= (ID_W+1)'(NUM_CH)) begin
                w_cand = w_cand - (ID_W+1)'(NUM_CH);
            end
            if (!w_pick_found &&
                (|(r_pending & (NUM_CH'(1) << w_cand[ID_W-1:0])))) begin
                w_pick_found = 1'b1;
                w_pick_id    = w_cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending | (ch_req & ~r_pending);
        w_ack_nxt     = '0;
        w_err_nxt     = '0;
        w_valid_nxt   = r_valid;
        w_id_nxt      = r_id;
        w_last_nxt    = r_last;
        w_cnt_nxt     = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_pick_found) begin
                    w_valid_nxt = 1'b1;
                    w_id_nxt    = w_pick_id;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                // Completion takes precedence over a coincident timeout.
                if (dst_done) begin
                    w_valid_nxt   = 1'b0;
                    w_pending_nxt = w_pending_nxt & ~w_id_oh;
                    w_ack_nxt     = w_id_oh;
                    w_last_nxt    = r_id;
                    w_state_nxt   = S_IDLE;
                end else if ((tmo_limit != '0) &&
                             (r_cnt == tmo_limit - TMO_W'(1))) begin
                    w_valid_nxt   = 1'b0;
                    w_pending_nxt = w_pending_nxt & ~w_id_oh;
                    w_err_nxt     = w_id_oh;
                    w_last_nxt    = r_id;
                    w_state_nxt   = S_IDLE;
                end else if (r_cnt != '1) begin
                    w_cnt_nxt = r_cnt + TMO_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pending <= '0;
            r_ack     <= '0;
            r_err     <= '0;
            r_valid   <= 1'b0;
            r_id      <= '0;
            r_last    <= ID_W'(NUM_CH - 1);
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_ack     <= w_ack_nxt;
            r_err     <= w_err_nxt;
            r_valid   <= w_valid_nxt;
            r_id      <= w_id_nxt;
            r_last    <= w_last_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    // A channel is ready exactly when it holds no pending request.
    assign ch_ready  = ~r_pending;
    assign ch_ack    = r_ack;
    assign ch_err    = r_err;
    assign dst_valid = r_valid;
    assign dst_id    = r_id;
    assign busy      = r_valid | (|r_pending);

endmodule
`default_nettype wire
